// File: rtl/w0rm_peripheral_counter.sv
// W0RM bus timer/counter peripheral: up/down counter with terminal-count pulse,
// optional auto-reload, and four byte-addressed registers read with one-cycle latency.
module w0rm_peripheral_counter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    TIME_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  mem_clk,
    input  logic                  cpu_reset,
    input  logic                  mem_valid_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output logic                  mem_valid_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  timer_reload
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_TIMER  = 2'd1;
    localparam logic [1:0] REG_RELOAD = 2'd2;

    // ctrl_r = {AUTO, DIR, EN}
    logic [2:0]            ctrl_r;
    logic [TIME_WIDTH-1:0] timer_r;
    logic [TIME_WIDTH-1:0] reload_r;
    logic                  term_r;
    logic                  valid_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  pulse_r;

    logic [ADDR_WIDTH-1:0] offset_s;
    logic [1:0]            reg_sel_s;
    logic                  hit_s;
    logic                  wr_s;
    logic                  rd_s;
    logic                  wr_ctrl_s;
    logic                  wr_timer_s;
    logic                  wr_reload_s;
    logic                  wr_status_s;
    logic                  terminal_s;
    logic [TIME_WIDTH-1:0] timer_nxt_s;
    logic [2:0]            ctrl_nxt_s;
    logic                  term_nxt_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    // Address decode; the subtraction makes the window relative to BASE_ADDR.
    always_comb begin
        offset_s    = mem_addr_i - BASE_ADDR;
        reg_sel_s   = offset_s[1:0];
        hit_s       = mem_valid_i && (offset_s < ADDR_WIDTH'(3'd4));
        wr_s        = hit_s && mem_write_i;
        rd_s        = hit_s && mem_read_i && !mem_write_i;
        wr_ctrl_s   = wr_s && (reg_sel_s == REG_CTRL);
        wr_timer_s  = wr_s && (reg_sel_s == REG_TIMER);
        wr_reload_s = wr_s && (reg_sel_s == REG_RELOAD);
        wr_status_s = wr_s && (reg_sel_s == 2'd3);
    end

    // Counter step; a bus write to TIMER suppresses counting for that cycle.
    always_comb begin
        terminal_s  = 1'b0;
        timer_nxt_s = timer_r;
        if (wr_timer_s) begin
            timer_nxt_s = mem_data_i[TIME_WIDTH-1:0];
        end else if (ctrl_r[0]) begin
            if (ctrl_r[1] == 1'b0) begin
                if (timer_r == reload_r) begin
                    terminal_s  = 1'b1;
                    timer_nxt_s = ctrl_r[2] ? {TIME_WIDTH{1'b0}} : timer_r;
                end else begin
                    timer_nxt_s = timer_r + TIME_WIDTH'(1'b1);
                end
            end else begin
                if (timer_r == {TIME_WIDTH{1'b0}}) begin
                    terminal_s  = 1'b1;
                    timer_nxt_s = ctrl_r[2] ? reload_r : timer_r;
                end else begin
                    timer_nxt_s = timer_r - TIME_WIDTH'(1'b1);
                end
            end
        end else begin
            timer_nxt_s = timer_r;
        end
    end

    // Control and status next state; CTRL writes win over one-shot EN clear,
    // and a terminal event wins over a write-1-to-clear of TERM.
    always_comb begin
        ctrl_nxt_s = ctrl_r;
        term_nxt_s = term_r;
        if (wr_ctrl_s) begin
            ctrl_nxt_s = mem_data_i[2:0];
        end else if (terminal_s && !ctrl_r[2]) begin
            ctrl_nxt_s = ctrl_r & 3'b110;
        end else begin
            ctrl_nxt_s = ctrl_r;
        end
        if (terminal_s) begin
            term_nxt_s = 1'b1;
        end else if (wr_status_s && mem_data_i[0]) begin
            term_nxt_s = 1'b0;
        end else begin
            term_nxt_s = term_r;
        end
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_data_s = {DATA_WIDTH{1'b0}};
        case (reg_sel_s)
            REG_CTRL:   rd_data_s[2:0]            = ctrl_r;
            REG_TIMER:  rd_data_s[TIME_WIDTH-1:0] = timer_r;
            REG_RELOAD: rd_data_s[TIME_WIDTH-1:0] = reload_r;
            default:    rd_data_s[0]              = term_r;
        endcase
    end

    // Architectural registers.
    always_ff @(posedge mem_clk or negedge cpu_reset) begin
        if (!cpu_reset) begin
            ctrl_r   <= 3'b000;
            timer_r  <= {TIME_WIDTH{1'b0}};
            reload_r <= {TIME_WIDTH{1'b0}};
            term_r   <= 1'b0;
        end else begin
            ctrl_r   <= ctrl_nxt_s;
            timer_r  <= timer_nxt_s;
            term_r   <= term_nxt_s;
            if (wr_reload_s) begin
                reload_r <= mem_data_i[TIME_WIDTH-1:0];
            end else begin
                reload_r <= reload_r;
            end
        end
    end

    // Registered bus response and terminal-count pulse.
    always_ff @(posedge mem_clk or negedge cpu_reset) begin
        if (!cpu_reset) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
            pulse_r <= 1'b0;
        end else begin
            valid_r <= rd_s;
            data_r  <= rd_s ? rd_data_s : {DATA_WIDTH{1'b0}};
            pulse_r <= terminal_s;
        end
    end

    assign mem_valid_o  = valid_r;
    assign mem_data_o   = data_r;
    assign timer_reload = pulse_r;

endmodule

// File: tb/tb_w0rm_peripheral_counter.sv
// Scoreboard bench for w0rm_peripheral_counter: a register-level reference model
// predicts read data and terminal pulses; a monitor compares them as the DUT emits them.
module tb_w0rm_peripheral_counter;

    localparam logic [31:0] BASE = 32'h0000_0100;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic        mem_clk     = 1'b0;
    logic        cpu_reset   = 1'b0;
    logic        mem_valid_i = 1'b0;
    logic        mem_read_i  = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [31:0] mem_addr_i  = 32'd0;
    logic [31:0] mem_data_i  = 32'd0;
    logic        mem_valid_o;
    logic [31:0] mem_data_o;
    logic        timer_reload;

    int  n_cmp  = 0;
    int  n_bad  = 0;
    int  cyc    = 0;
    bit  mon_en = 1'b0;
    rd_t rd_q[$];
    int  pulse_q[$];
    rd_t mon_e;

    // Reference state, in register terms
    bit          m_en, m_dir, m_auto, m_term;
    logic [31:0] m_timer, m_reload;

    w0rm_peripheral_counter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIME_WIDTH(32), .BASE_ADDR(BASE)
    ) dut (
        .mem_clk(mem_clk), .cpu_reset(cpu_reset),
        .mem_valid_i(mem_valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_valid_o(mem_valid_o), .mem_data_o(mem_data_o), .timer_reload(timer_reload)
    );

    always #5 mem_clk = ~mem_clk;
    always @(posedge mem_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_dir = 0; m_auto = 0; m_term = 0;
        m_timer = 32'd0; m_reload = 32'd0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] off);
        case (off)
            2'd0:    return {29'd0, m_auto, m_dir, m_en};
            2'd1:    return m_timer;
            2'd2:    return m_reload;
            default: return {31'd0, m_term};
        endcase
    endfunction

    // What happens to the register set at the next clock edge for one bus request.
    task automatic model_step(input bit v, input bit r, input bit w,
                              input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        logic [31:0] start, target;
        bit hit, wr, rd, fire;
        off  = a - BASE;
        hit  = v && (off < 32'd4);
        wr   = hit && w;
        rd   = hit && r && !w;
        fire = 0;
        if (rd) rd_q.push_back('{cyc + 1, model_read(off[1:0])});
        if (m_en && !(wr && off == 32'd1)) begin
            start  = m_dir ? m_reload : 32'd0;
            target = m_dir ? 32'd0 : m_reload;
            if (m_timer == target) begin
                fire = 1;
                if (m_auto) m_timer = start;
                else        m_en = 0;
            end else begin
                m_timer = m_dir ? m_timer - 32'd1 : m_timer + 32'd1;
            end
        end
        if (wr) begin
            case (off[1:0])
                2'd0:    {m_auto, m_dir, m_en} = d[2:0];
                2'd1:    m_timer = d;
                2'd2:    m_reload = d;
                default: if (d[0]) m_term = 0;
            endcase
        end
        if (fire) begin
            m_term = 1;
            pulse_q.push_back(cyc + 1);
        end
    endtask

    task automatic bus(input bit v, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
        @(posedge mem_clk);
        #2;
        mem_valid_i = v; mem_read_i = r; mem_write_i = w;
        mem_addr_i = a; mem_data_i = d;
        model_step(v, r, w, a, d);
    endtask

    task automatic wr_reg(input int off, input logic [31:0] d);
        bus(1, 0, 1, BASE + off, d);
    endtask

    task automatic rd_reg(input int off);
        bus(1, 1, 0, BASE + off, 32'd0);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must drop at once.
    task automatic mid_reset();
        @(negedge mem_clk);
        #1;
        mon_en = 0;
        cpu_reset = 0;
        #1;
        check("async_rst_valid", mem_valid_o, 32'd0);
        check("async_rst_data", mem_data_o, 32'd0);
        check("async_rst_pulse", timer_reload, 32'd0);
        model_reset();
        rd_q.delete();
        pulse_q.delete();
        mem_valid_i = 0; mem_read_i = 0; mem_write_i = 0;
        repeat (2) @(posedge mem_clk);
        #2;
        cpu_reset = 1;
        mon_en = 1;
    endtask

    // Monitor: consumes expectations only when the DUT presents an output.
    always @(negedge mem_clk) begin
        if (mon_en) begin
            if (mem_valid_o) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL read_spurious: got valid with data %h, expected no response", mem_data_o);
                end else begin
                    mon_e = rd_q.pop_front();
                    check("read_latency", cyc, mon_e.due);
                    check("read_data", mem_data_o, mon_e.data);
                end
            end else begin
                check("idle_data_zero", mem_data_o, 32'd0);
                if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
                    mon_e = rd_q.pop_front();
                    n_cmp++; n_bad++;
                    $display("FAIL read_missing: got no valid, expected data %h", mon_e.data);
                end
            end
            if (timer_reload) begin
                if (pulse_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL pulse_spurious: got timer_reload=1 at cycle %0d, expected 0", cyc);
                end else begin
                    check("pulse_cycle", cyc, pulse_q.pop_front());
                end
            end else if (pulse_q.size() > 0 && pulse_q[0] <= cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL pulse_missing: got timer_reload=0, expected pulse at cycle %0d", pulse_q.pop_front());
            end
        end
    end

    task automatic rand_op();
        int k;
        logic [31:0] d;
        k = $urandom_range(0, 99);
        d = $urandom;
        if (k < 30)      rd_reg($urandom_range(0, 3));
        else if (k < 40) wr_reg(0, {29'd0, d[2:0]});
        else if (k < 47) wr_reg(2, $urandom_range(0, 6));
        else if (k < 52) wr_reg(1, d[0] ? 32'($urandom_range(0, 8)) : 32'hFFFF_FFFC + {29'd0, d[3:1]});
        else if (k < 57) wr_reg(3, {31'd0, d[0]});
        else if (k < 62) bus(1, 1, 1, BASE + $urandom_range(0, 3), d & 32'h7);
        else if (k < 66) bus(1, d[4], d[5], d[6] ? BASE + 32'd4 + {28'd0, d[11:8]} : BASE - 32'd1, d & 32'h7);
        else if (k < 70) bus(0, 1, d[7], BASE + $urandom_range(0, 3), d & 32'h7);
        else             bus(0, 0, 0, 32'd0, 32'd0);
    endtask

    initial begin
        model_reset();
        // Reads under held reset produce nothing
        for (int i = 0; i < 4; i++) begin
            @(posedge mem_clk);
            #2;
            mem_valid_i = 1; mem_read_i = 1; mem_write_i = 0; mem_addr_i = BASE + i;
            @(posedge mem_clk);
            #1;
            check("rst_hold_valid", mem_valid_o, 32'd0);
            check("rst_hold_data", mem_data_o, 32'd0);
            check("rst_hold_pulse", timer_reload, 32'd0);
        end
        mem_valid_i = 0; mem_read_i = 0;
        @(posedge mem_clk);
        #2;
        cpu_reset = 1;
        mon_en = 1;

        for (int i = 0; i < 4; i++) rd_reg(i);
        wr_reg(2, 32'h5A);
        rd_reg(2);

        // Up, auto-reload, period 4
        wr_reg(2, 32'd3);
        wr_reg(0, 32'h5);
        repeat (12) rd_reg(1);
        wr_reg(0, 32'h0);

        // Down, one-shot from 2
        wr_reg(1, 32'd2);
        wr_reg(0, 32'h3);
        repeat (6) rd_reg(1);
        rd_reg(0);
        rd_reg(3);
        wr_reg(3, 32'h1);

        // Up through FE, FF, 00 with reload at FF
        wr_reg(2, 32'hFF);
        wr_reg(1, 32'hFE);
        wr_reg(0, 32'h5);
        repeat (4) rd_reg(1);
        rd_reg(3);
        wr_reg(3, 32'h1);
        rd_reg(3);
        wr_reg(0, 32'h0);

        // Written timer above RELOAD wraps through zero
        wr_reg(2, 32'd2);
        wr_reg(1, 32'hFFFF_FFFE);
        wr_reg(0, 32'h1);
        repeat (6) rd_reg(1);

        // Out-of-window accesses
        rd_reg(4);
        bus(1, 1, 0, BASE - 32'd1, 32'd0);
        bus(1, 0, 1, BASE + 32'd4, 32'h7);
        for (int i = 0; i < 4; i++) rd_reg(i);

        // Reset in the middle of counting
        wr_reg(2, 32'd3);
        wr_reg(0, 32'h5);
        repeat (3) rd_reg(1);
        mid_reset();
        for (int i = 0; i < 4; i++) rd_reg(i);

        repeat (3000) rand_op();
        repeat (4) bus(0, 0, 0, 32'd0, 32'd0);
        @(negedge mem_clk);
        #1;
        check("drain_reads", rd_q.size(), 32'd0);
        check("drain_pulses", pulse_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
